// File: rtl/fft_frame_sched.sv
// Frame scheduler around an FFT input buffer: fills N samples, waits for the
// buffer to signal loaded, then drains N results downstream with back-pressure.
module fft_frame_sched #(
    parameter int unsigned total_bits = 32,
    parameter int unsigned N          = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ENABLE,
    input  logic                  ABORT,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [total_bits-1:0] S_REAL,
    input  logic [total_bits-1:0] S_IMAG,
    output logic                  BUF_START,
    output logic                  BUF_ED,
    output logic [total_bits-1:0] BUF_DREAL,
    output logic [total_bits-1:0] BUF_DIMAG,
    input  logic                  BUF_RDY,
    input  logic [total_bits-1:0] BUF_DOREAL,
    input  logic [total_bits-1:0] BUF_DOIMAG,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [total_bits-1:0] M_REAL,
    output logic [total_bits-1:0] M_IMAG,
    output logic                  M_LAST,
    output logic [15:0]           FRAME_CNT,
    output logic                  ERR
);

    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StClear, StFill, StWaitRdy, StPrime, StDrain, StErr
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] fill_cnt_q;
    logic [CntW-1:0] drain_cnt_q;
    logic [TmrW-1:0] timer_q;
    logic [15:0]     frame_cnt_q;
    logic            err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else if (ABORT && state_q != StIdle && state_q != StErr) begin
            // Frame discarded; CLEAR re-initialises the counters.
            state_q <= StClear;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ENABLE) state_q <= StClear;
                end
                StClear: begin
                    fill_cnt_q  <= '0;
                    drain_cnt_q <= '0;
                    timer_q     <= '0;
                    state_q     <= StFill;
                end
                StFill: begin
                    if (S_VALID) begin
                        fill_cnt_q <= fill_cnt_q + CntW'(1);
                        if (fill_cnt_q == CntLast) state_q <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (BUF_RDY) begin
                        state_q <= StPrime;
                    end else if (timer_q == TmrLast) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TmrW'(1);
                    end
                end
                StPrime: begin
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (M_READY) begin
                        drain_cnt_q <= drain_cnt_q + CntW'(1);
                        if (drain_cnt_q == CntLast) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state_q     <= ENABLE ? StClear : StIdle;
                        end
                    end
                end
                StErr: begin
                    if (ABORT) begin
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes decode straight from the state register, so reset clears them at once.
    assign S_READY   = (state_q == StFill);
    assign BUF_START = (state_q == StClear);
    assign M_VALID   = (state_q == StDrain);
    assign M_LAST    = M_VALID && (drain_cnt_q == CntLast);

    always_comb begin
        BUF_ED = 1'b0;
        unique case (state_q)
            StFill:  BUF_ED = S_VALID;
            StPrime: BUF_ED = 1'b1;
            StDrain: BUF_ED = M_READY;
            default: BUF_ED = 1'b0;
        endcase
    end

    assign BUF_DREAL = S_READY ? S_REAL : '0;
    assign BUF_DIMAG = S_READY ? S_IMAG : '0;
    assign M_REAL    = M_VALID ? BUF_DOREAL : '0;
    assign M_IMAG    = M_VALID ? BUF_DOIMAG : '0;
    assign FRAME_CNT = frame_cnt_q;
    assign ERR       = err_q;

endmodule
